// File: rtl/riscv_pkg.sv
// RV32 constants shared between the instruction mux and the M-extension unit.
package riscv_pkg;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic logic f3_rs1_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic f3_rs2_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/m_ext_signfix.sv
// Conditional two's-complement negate; yields |x| when i_neg is the sign of x.
module m_ext_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/m_ext_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add / restoring divide,
// one bit per cycle, sharing a single accumulator/shift register pair.
module m_ext_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iSTART,
    input  logic [2:0]      iFUNCT3,
    input  logic [XLEN-1:0] iALU_IN1_M,
    input  logic [XLEN-1:0] iALU_IN2_M,
    output logic [XLEN-1:0] oALU_OUT_M,
    output logic            oBUSY,
    output logic            oDONE
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;

    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_q;
    logic [XLEN-1:0] r_op2;
    logic [XLEN-1:0] r_res;
    logic [2:0]      r_funct3;
    logic            r_neg;
    logic [CNT_W-1:0] r_cnt;

    logic            w_s1;
    logic            w_s2;
    logic            w_neg;
    logic [XLEN-1:0] w_abs1;
    logic [XLEN-1:0] w_abs2;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic            w_last;

    logic [XLEN:0]   w_mul_sum;
    logic [XLEN:0]   w_div_shl;
    logic [XLEN:0]   w_div_diff;
    logic            w_div_ge;
    logic [XLEN-1:0] w_acc_nx;
    logic [XLEN-1:0] w_q_nx;

    logic [2*XLEN-1:0] w_fix_in;
    logic [2*XLEN-1:0] w_fix;
    logic [XLEN-1:0]   w_fix_res;

    // Operand preparation
    assign w_s1 = f3_rs1_signed(iFUNCT3) & iALU_IN1_M[XLEN-1];
    assign w_s2 = f3_rs2_signed(iFUNCT3) & iALU_IN2_M[XLEN-1];
    // Remainder follows the dividend; product and quotient follow the sign xor.
    assign w_neg = (iFUNCT3[2] && iFUNCT3[1]) ? w_s1 : (w_s1 ^ w_s2);

    m_ext_signfix #(.W(XLEN)) u_abs1 (
        .i_val (iALU_IN1_M),
        .i_neg (w_s1),
        .o_val (w_abs1)
    );

    m_ext_signfix #(.W(XLEN)) u_abs2 (
        .i_val (iALU_IN2_M),
        .i_neg (w_s2),
        .o_val (w_abs2)
    );

    assign w_div_zero = iFUNCT3[2] && (iALU_IN2_M == '0);
    assign w_ovf      = ((iFUNCT3 == F3_DIV) || (iFUNCT3 == F3_REM)) &&
                        (iALU_IN1_M == {1'b1, {(XLEN-1){1'b0}}}) &&
                        (iALU_IN2_M == '1);
    assign w_special  = w_div_zero || w_ovf;

    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = iFUNCT3[1] ? iALU_IN1_M : '1;
        end else if (w_ovf) begin
            w_special_res = iFUNCT3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // One iteration of the shared engine
    assign w_mul_sum  = {1'b0, r_acc} + {1'b0, (r_q[0] ? r_op2 : '0)};
    assign w_div_shl  = {r_acc, r_q[XLEN-1]};
    assign w_div_diff = w_div_shl - {1'b0, r_op2};
    assign w_div_ge   = (w_div_shl >= {1'b0, r_op2});

    always_comb begin
        if (r_funct3[2]) begin
            w_acc_nx = w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shl[XLEN-1:0];
            w_q_nx   = {r_q[XLEN-2:0], w_div_ge};
        end else begin
            w_acc_nx = w_mul_sum[XLEN:1];
            w_q_nx   = {w_mul_sum[0], r_q[XLEN-1:1]};
        end
    end

    assign w_last = (r_cnt == CNT_W'(XLEN-1));

    // Result sign correction: one 2*XLEN negator covers product, quotient and remainder
    always_comb begin
        if (!r_funct3[2]) begin
            w_fix_in = {w_acc_nx, w_q_nx};
        end else if (!r_funct3[1]) begin
            w_fix_in = {{XLEN{1'b0}}, w_q_nx};
        end else begin
            w_fix_in = {{XLEN{1'b0}}, w_acc_nx};
        end
    end

    m_ext_signfix #(.W(2*XLEN)) u_fix (
        .i_val (w_fix_in),
        .i_neg (r_neg),
        .o_val (w_fix)
    );

    assign w_fix_res = ((r_funct3 == F3_MUL) || r_funct3[2]) ? w_fix[XLEN-1:0]
                                                             : w_fix[2*XLEN-1:XLEN];

    // FSM: state register
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: if (iSTART) w_state_nx = w_special ? S_DONE : S_CALC;
            S_CALC: if (w_last) w_state_nx = S_DONE;
            S_DONE: w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        oBUSY = (r_state != S_IDLE);
        oDONE = (r_state == S_DONE);
    end

    // Datapath
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_acc    <= '0;
            r_q      <= '0;
            r_op2    <= '0;
            r_res    <= '0;
            r_funct3 <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (iSTART) begin
                        r_funct3 <= iFUNCT3;
                        r_neg    <= w_neg;
                        r_acc    <= '0;
                        r_q      <= w_abs1;
                        r_op2    <= w_abs2;
                        r_cnt    <= '0;
                        if (w_special) r_res <= w_special_res;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_nx;
                    r_q   <= w_q_nx;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) r_res <= w_fix_res;
                end
                default: ;
            endcase
        end
    end

    assign oALU_OUT_M = r_res;

endmodule

// File: tb/tb_m_ext_unit.sv
// Scoreboard bench for m_ext_unit: directed vectors queued at issue time,
// compared by an independent monitor whenever oDONE is seen.
module tb_m_ext_unit;

    logic        iCLK;
    logic        iRST;
    logic        iSTART;
    logic [2:0]  iFUNCT3;
    logic [31:0] iALU_IN1_M;
    logic [31:0] iALU_IN2_M;
    logic [31:0] oALU_OUT_M;
    logic        oBUSY;
    logic        oDONE;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          t_start;
        string       name;
    } exp_t;

    exp_t q_exp[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    m_ext_unit #(.XLEN(32)) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iSTART     (iSTART),
        .iFUNCT3    (iFUNCT3),
        .iALU_IN1_M (iALU_IN1_M),
        .iALU_IN2_M (iALU_IN2_M),
        .oALU_OUT_M (oALU_OUT_M),
        .oBUSY      (oBUSY),
        .oDONE      (oDONE)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pops the scoreboard on every oDONE
    initial begin
        exp_t e;
        forever begin
            @(posedge iCLK);
            cyc++;
            #1;
            if (oDONE === 1'b1) begin
                if (q_exp.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q_exp.pop_front();
                    chk({e.name, "_result"}, oALU_OUT_M, e.res);
                    chk({e.name, "_latency"}, 32'(cyc - e.t_start + 1), 32'(e.lat));
                end
            end
        end
    end

    // Called at a negedge while the DUT is idle; returns at a negedge in IDLE.
    task automatic issue(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat,
                         input int stray);
        exp_t e;
        iFUNCT3    = f3;
        iALU_IN1_M = a;
        iALU_IN2_M = b;
        iSTART     = 1'b1;
        e.res = exp; e.lat = lat; e.t_start = cyc + 1; e.name = name;
        q_exp.push_back(e);
        for (int k = 1; k <= lat + 1; k++) begin
            @(posedge iCLK);
            #1;
            iSTART     = 1'b0;
            iFUNCT3    = 3'($urandom_range(7));
            iALU_IN1_M = $urandom;
            iALU_IN2_M = $urandom;
            chk({name, "_busy"}, 32'(oBUSY), 32'(k <= lat));
            @(negedge iCLK);
            if (k == stray) iSTART = 1'b1;
        end
        iSTART = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        iRST       = 1'b1;
        iSTART     = 1'b0;
        iFUNCT3    = 3'b000;
        iALU_IN1_M = '0;
        iALU_IN2_M = '0;
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        iRST = 1'b0;
        chk("reset_out",  oALU_OUT_M,   32'h0);
        chk("reset_busy", 32'(oBUSY),   32'd0);
        chk("reset_done", 32'(oDONE),   32'd0);

        // Reset and start together: reset wins
        iRST = 1'b1; iSTART = 1'b1; iFUNCT3 = 3'b000;
        iALU_IN1_M = 32'd3; iALU_IN2_M = 32'd4;
        @(posedge iCLK); #1;
        chk("rst_start_busy", 32'(oBUSY), 32'd0);
        @(negedge iCLK);
        iRST = 1'b0; iSTART = 1'b0;

        issue("mul",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0);
        issue("mulh",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 0);
        issue("mulhu",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0);
        issue("mulhsu",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0);
        issue("mul_pos", 3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 33, 0);
        issue("mulh_m1", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, 0);
        issue("div",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 0);
        issue("rem",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 0);
        issue("divu",    3'b101, 32'd7,        32'd2,        32'd3,        33, 0);
        issue("remu",    3'b111, 32'd7,        32'd2,        32'd1,        33, 0);
        issue("rem_negd",3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33, 0);
        issue("divu_big",3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33, 0);
        issue("div0",    3'b100, 32'd5,        32'd0,        32'hFFFFFFFF,  1, 0);
        issue("remu0",   3'b111, 32'd5,        32'd0,        32'd5,         1, 0);
        issue("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,  1, 0);
        issue("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000,  1, 0);
        issue("mul_stray",3'b000, 32'd7,       32'hFFFFFFFD, 32'hFFFFFFEB, 33, 5);
        issue("divu_max",3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33, 0);

        // Abort a DIV with reset in cycle 10
        iFUNCT3 = 3'b100; iALU_IN1_M = 32'd100; iALU_IN2_M = 32'd7; iSTART = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge iCLK); #1;
            iSTART = 1'b0;
            @(negedge iCLK);
            if (k == 10) iRST = 1'b1;
        end
        @(posedge iCLK); #1;
        chk("abort_busy", 32'(oBUSY), 32'd0);
        chk("abort_out",  oALU_OUT_M, 32'h0);
        chk("abort_done", 32'(oDONE), 32'd0);
        @(negedge iCLK);
        iRST = 1'b0;
        repeat (40) @(negedge iCLK);

        issue("post_abort", 3'b101, 32'd100, 32'd7, 32'd14, 33, 0);

        repeat (5) @(negedge iCLK);
        chk("scoreboard_empty", 32'(q_exp.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
